// File: rtl/axi_lite_mem_arbiter.sv
// axi_lite_mem_arbiter: two-master round-robin AXI-lite arbiter, one transaction in flight
module axi_lite_mem_arbiter #(
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 128
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        m0_aw_valid,
    output logic                        m0_aw_ready,
    input  logic [AXI_ADDR_WIDTH-1:0]   m0_aw_addr,
    input  logic                        m0_w_valid,
    output logic                        m0_w_ready,
    input  logic [AXI_DATA_WIDTH-1:0]   m0_w_data,
    input  logic [AXI_DATA_WIDTH/8-1:0] m0_w_strb,
    output logic                        m0_b_valid,
    input  logic                        m0_b_ready,
    output logic [1:0]                  m0_b_resp,
    input  logic                        m0_ar_valid,
    output logic                        m0_ar_ready,
    input  logic [AXI_ADDR_WIDTH-1:0]   m0_ar_addr,
    output logic                        m0_r_valid,
    input  logic                        m0_r_ready,
    output logic [AXI_DATA_WIDTH-1:0]   m0_r_data,
    output logic [1:0]                  m0_r_resp,
    input  logic                        m1_aw_valid,
    output logic                        m1_aw_ready,
    input  logic [AXI_ADDR_WIDTH-1:0]   m1_aw_addr,
    input  logic                        m1_w_valid,
    output logic                        m1_w_ready,
    input  logic [AXI_DATA_WIDTH-1:0]   m1_w_data,
    input  logic [AXI_DATA_WIDTH/8-1:0] m1_w_strb,
    output logic                        m1_b_valid,
    input  logic                        m1_b_ready,
    output logic [1:0]                  m1_b_resp,
    input  logic                        m1_ar_valid,
    output logic                        m1_ar_ready,
    input  logic [AXI_ADDR_WIDTH-1:0]   m1_ar_addr,
    output logic                        m1_r_valid,
    input  logic                        m1_r_ready,
    output logic [AXI_DATA_WIDTH-1:0]   m1_r_data,
    output logic [1:0]                  m1_r_resp,
    output logic                        s_aw_valid,
    input  logic                        s_aw_ready,
    output logic [AXI_ADDR_WIDTH-1:0]   s_aw_addr,
    output logic                        s_w_valid,
    input  logic                        s_w_ready,
    output logic [AXI_DATA_WIDTH-1:0]   s_w_data,
    output logic [AXI_DATA_WIDTH/8-1:0] s_w_strb,
    input  logic                        s_b_valid,
    output logic                        s_b_ready,
    input  logic [1:0]                  s_b_resp,
    output logic                        s_ar_valid,
    input  logic                        s_ar_ready,
    output logic [AXI_ADDR_WIDTH-1:0]   s_ar_addr,
    input  logic                        s_r_valid,
    output logic                        s_r_ready,
    input  logic [AXI_DATA_WIDTH-1:0]   s_r_data,
    input  logic [1:0]                  s_r_resp,
    output logic [2:0]                  grant_state
);
    typedef enum logic [2:0] {IDLE = 3'd0, R0 = 3'd1, W0 = 3'd2, R1 = 3'd3, W1 = 3'd4} state_t;

    state_t state, next_state;
    logic   last_grant, next_grant;
    logic   r0, w0, r1, w1, req0, req1, sel1, done;

    // state and fairness pointer
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            last_grant <= 1'b0;
        end else begin
            state      <= next_state;
            last_grant <= next_grant;
        end
    end

    // arbitrate in IDLE, hold the grant until the response handshake
    always_comb begin
        req0       = m0_aw_valid | m0_ar_valid;
        req1       = m1_aw_valid | m1_ar_valid;
        sel1       = req1 & (~req0 | ~last_grant);
        done       = (r0 & s_r_valid & m0_r_ready) | (w0 & s_b_valid & m0_b_ready) |
                     (r1 & s_r_valid & m1_r_ready) | (w1 & s_b_valid & m1_b_ready);
        next_state = done ? IDLE : state;
        next_grant = last_grant;
        if (state == IDLE && (req0 | req1)) begin
            next_grant = sel1;
            next_state = sel1 ? (m1_aw_valid ? W1 : R1) : (m0_aw_valid ? W0 : R0);
        end
    end

    // combinational channel steering from the registered grant
    always_comb begin
        r0          = state == R0;
        w0          = state == W0;
        r1          = state == R1;
        w1          = state == W1;
        grant_state = state;
        s_aw_valid  = w0 ? m0_aw_valid : w1 ? m1_aw_valid : 1'b0;
        s_aw_addr   = w0 ? m0_aw_addr  : w1 ? m1_aw_addr  : '0;
        s_w_valid   = w0 ? m0_w_valid  : w1 ? m1_w_valid  : 1'b0;
        s_w_data    = w0 ? m0_w_data   : w1 ? m1_w_data   : '0;
        s_w_strb    = w0 ? m0_w_strb   : w1 ? m1_w_strb   : '0;
        s_b_ready   = w0 ? m0_b_ready  : w1 ? m1_b_ready  : 1'b0;
        s_ar_valid  = r0 ? m0_ar_valid : r1 ? m1_ar_valid : 1'b0;
        s_ar_addr   = r0 ? m0_ar_addr  : r1 ? m1_ar_addr  : '0;
        s_r_ready   = r0 ? m0_r_ready  : r1 ? m1_r_ready  : 1'b0;
        m0_aw_ready = w0 & s_aw_ready;
        m0_w_ready  = w0 & s_w_ready;
        m0_b_valid  = w0 & s_b_valid;
        m0_b_resp   = w0 ? s_b_resp : 2'b00;
        m0_ar_ready = r0 & s_ar_ready;
        m0_r_valid  = r0 & s_r_valid;
        m0_r_data   = r0 ? s_r_data : '0;
        m0_r_resp   = r0 ? s_r_resp : 2'b00;
        m1_aw_ready = w1 & s_aw_ready;
        m1_w_ready  = w1 & s_w_ready;
        m1_b_valid  = w1 & s_b_valid;
        m1_b_resp   = w1 ? s_b_resp : 2'b00;
        m1_ar_ready = r1 & s_ar_ready;
        m1_r_valid  = r1 & s_r_valid;
        m1_r_data   = r1 ? s_r_data : '0;
        m1_r_resp   = r1 ? s_r_resp : 2'b00;
    end
endmodule

// File: tb/tb_axi_lite_mem_arbiter.sv
// tb_axi_lite_mem_arbiter: scoreboard bench with a behavioural slave
module tb_axi_lite_mem_arbiter;
    localparam int A = 64;
    localparam int D = 128;

    logic clk = 0, rstn = 0;
    logic m0_aw_valid, m0_aw_ready, m0_w_valid, m0_w_ready, m0_b_valid, m0_b_ready;
    logic m0_ar_valid, m0_ar_ready, m0_r_valid, m0_r_ready;
    logic [A-1:0] m0_aw_addr, m0_ar_addr;
    logic [D-1:0] m0_w_data, m0_r_data;
    logic [D/8-1:0] m0_w_strb;
    logic [1:0] m0_b_resp, m0_r_resp;
    logic m1_aw_valid, m1_aw_ready, m1_w_valid, m1_w_ready, m1_b_valid, m1_b_ready;
    logic m1_ar_valid, m1_ar_ready, m1_r_valid, m1_r_ready;
    logic [A-1:0] m1_aw_addr, m1_ar_addr;
    logic [D-1:0] m1_w_data, m1_r_data;
    logic [D/8-1:0] m1_w_strb;
    logic [1:0] m1_b_resp, m1_r_resp;
    logic s_aw_valid, s_aw_ready, s_w_valid, s_w_ready, s_b_valid, s_b_ready;
    logic s_ar_valid, s_ar_ready, s_r_valid, s_r_ready;
    logic [A-1:0] s_aw_addr, s_ar_addr, raddr, sw_addr;
    logic [D-1:0] s_w_data, s_r_data, sw_data;
    logic [D/8-1:0] s_w_strb, sw_strb;
    logic [1:0] s_b_resp, s_r_resp, b_resp_cfg;
    logic [2:0] grant_state, prev_gs = 0;
    logic w_gate, aw_got, w_got, rpend;
    logic [3:0] rcnt;

    typedef struct {int m; bit w; logic [D-1:0] data; logic [1:0] resp;} exp_t;
    exp_t sb[$];
    logic [2:0] trace[$];
    int n_chk = 0, n_fail = 0, b_cnt1 = 0, m1r_cnt = 0;

    axi_lite_mem_arbiter #(.AXI_ADDR_WIDTH(A), .AXI_DATA_WIDTH(D)) dut (
        .clk(clk), .rstn(rstn),
        .m0_aw_valid(m0_aw_valid), .m0_aw_ready(m0_aw_ready), .m0_aw_addr(m0_aw_addr),
        .m0_w_valid(m0_w_valid), .m0_w_ready(m0_w_ready), .m0_w_data(m0_w_data), .m0_w_strb(m0_w_strb),
        .m0_b_valid(m0_b_valid), .m0_b_ready(m0_b_ready), .m0_b_resp(m0_b_resp),
        .m0_ar_valid(m0_ar_valid), .m0_ar_ready(m0_ar_ready), .m0_ar_addr(m0_ar_addr),
        .m0_r_valid(m0_r_valid), .m0_r_ready(m0_r_ready), .m0_r_data(m0_r_data), .m0_r_resp(m0_r_resp),
        .m1_aw_valid(m1_aw_valid), .m1_aw_ready(m1_aw_ready), .m1_aw_addr(m1_aw_addr),
        .m1_w_valid(m1_w_valid), .m1_w_ready(m1_w_ready), .m1_w_data(m1_w_data), .m1_w_strb(m1_w_strb),
        .m1_b_valid(m1_b_valid), .m1_b_ready(m1_b_ready), .m1_b_resp(m1_b_resp),
        .m1_ar_valid(m1_ar_valid), .m1_ar_ready(m1_ar_ready), .m1_ar_addr(m1_ar_addr),
        .m1_r_valid(m1_r_valid), .m1_r_ready(m1_r_ready), .m1_r_data(m1_r_data), .m1_r_resp(m1_r_resp),
        .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .s_aw_addr(s_aw_addr),
        .s_w_valid(s_w_valid), .s_w_ready(s_w_ready), .s_w_data(s_w_data), .s_w_strb(s_w_strb),
        .s_b_valid(s_b_valid), .s_b_ready(s_b_ready), .s_b_resp(s_b_resp),
        .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_addr(s_ar_addr),
        .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_data(s_r_data), .s_r_resp(s_r_resp),
        .grant_state(grant_state)
    );

    always #5 clk = ~clk;
    assign s_w_ready = w_gate;

    function automatic logic [D-1:0] rdata(input logic [A-1:0] a);
        return {a ^ 64'h1122_3344_5566_7788, a};
    endfunction

    task automatic chk(input string tag, input logic [D-1:0] got, input logic [D-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_rsp(input int m, input bit w, input logic [D-1:0] data, input logic [1:0] resp);
        exp_t e;
        chk("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("rsp_master", m, e.m);
            chk("rsp_kind", w, e.w);
            chk("rsp_data", data, e.data);
            chk("rsp_resp", resp, e.resp);
            chk("rsp_in_grant", grant_state, m == 0 ? (w ? 3'd2 : 3'd1) : (w ? 3'd4 : 3'd3));
        end
    endtask

    task automatic push(input int m, input bit w, input logic [D-1:0] data, input logic [1:0] resp);
        exp_t e;
        e.m = m; e.w = w; e.data = data; e.resp = resp;
        sb.push_back(e);
    endtask

    // slave: ar/aw always ready, read data two cycles after AR, B once AW and W are both in
    always @(posedge clk) begin
        if (!rstn) begin
            s_r_valid <= 0; s_b_valid <= 0; aw_got <= 0; w_got <= 0; rpend <= 0; rcnt <= 0;
        end else begin
            if (s_ar_valid && s_ar_ready) begin
                rpend <= 1; rcnt <= 2; raddr <= s_ar_addr;
            end else if (rpend) begin
                if (rcnt == 1) begin
                    s_r_valid <= 1; s_r_data <= rdata(raddr); s_r_resp <= 0; rpend <= 0;
                end else rcnt <= rcnt - 1;
            end
            if (s_r_valid && s_r_ready) s_r_valid <= 0;
            if (s_aw_valid && s_aw_ready) begin aw_got <= 1; sw_addr <= s_aw_addr; end
            if (s_w_valid && s_w_ready) begin w_got <= 1; sw_data <= s_w_data; sw_strb <= s_w_strb; end
            if ((aw_got || (s_aw_valid && s_aw_ready)) && (w_got || (s_w_valid && s_w_ready)) && !s_b_valid) begin
                s_b_valid <= 1; s_b_resp <= b_resp_cfg; aw_got <= 0; w_got <= 0;
            end
            if (s_b_valid && s_b_ready) s_b_valid <= 0;
        end
    end

    // response monitor and grant trace
    always @(negedge clk) begin
        if (m0_r_valid && m0_r_ready) check_rsp(0, 0, m0_r_data, m0_r_resp);
        if (m1_r_valid && m1_r_ready) check_rsp(1, 0, m1_r_data, m1_r_resp);
        if (m0_b_valid && m0_b_ready) check_rsp(0, 1, '0, m0_b_resp);
        if (m1_b_valid && m1_b_ready) check_rsp(1, 1, '0, m1_b_resp);
        if (m1_b_valid && m1_b_ready) b_cnt1 <= b_cnt1 + 1;
        if (m1_r_valid) m1r_cnt <= m1r_cnt + 1;
        if (grant_state != prev_gs) trace.push_back(grant_state);
        prev_gs <= grant_state;
    end

    task automatic do_read(input int m, input logic [A-1:0] a);
        bit done = 0;
        if (m == 0) begin m0_ar_valid = 1; m0_ar_addr = a; end
        else begin m1_ar_valid = 1; m1_ar_addr = a; end
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (m == 0 ? m0_ar_ready : m1_ar_ready) begin
                @(posedge clk); #1; done = 1;
            end
        end
        if (m == 0) m0_ar_valid = 0; else m1_ar_valid = 0;
        chk("ar_handshake", done, 1);
    endtask

    task automatic do_write(input int m, input logic [A-1:0] a, input logic [D-1:0] d);
        bit av = 1, wv = 1, ah, wh;
        if (m == 0) begin m0_aw_addr = a; m0_w_data = d; m0_w_strb = '1; end
        else begin m1_aw_addr = a; m1_w_data = d; m1_w_strb = '1; end
        for (int i = 0; i < 200 && (av || wv); i++) begin
            if (m == 0) begin m0_aw_valid = av; m0_w_valid = wv; end
            else begin m1_aw_valid = av; m1_w_valid = wv; end
            @(negedge clk);
            ah = av && (m == 0 ? m0_aw_ready : m1_aw_ready);
            wh = wv && (m == 0 ? m0_w_ready : m1_w_ready);
            @(posedge clk); #1;
            if (ah) av = 0;
            if (wh) wv = 0;
        end
        if (m == 0) begin m0_aw_valid = 0; m0_w_valid = 0; end
        else begin m1_aw_valid = 0; m1_w_valid = 0; end
        chk("w_handshake", av | wv, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && grant_state == 0) break;
        end
        chk("drain", sb.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_trace(input int n, input logic [2:0] e0, e1, e2, e3);
        logic [2:0] e[4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        chk("trace_len", trace.size(), n);
        for (int i = 0; i < n && i < trace.size(); i++) chk($sformatf("trace%0d", i), trace[i], e[i]);
        trace.delete();
    endtask

    initial begin
        int c, b0;
        bit seen;
        {m0_aw_valid, m0_w_valid, m0_ar_valid, m1_aw_valid, m1_w_valid, m1_ar_valid} = '0;
        {m0_aw_addr, m0_ar_addr, m1_aw_addr, m1_ar_addr} = '0;
        {m0_w_data, m1_w_data, m0_w_strb, m1_w_strb} = '0;
        {m0_b_ready, m0_r_ready, m1_b_ready, m1_r_ready} = 4'hf;
        s_aw_ready = 1; s_ar_ready = 1; w_gate = 1; b_resp_cfg = 0;
        @(negedge clk);
        chk("rst_state", grant_state, 0);
        chk("rst_handshakes", {s_aw_valid, s_w_valid, s_b_ready, s_ar_valid, s_r_ready,
            m0_aw_ready, m0_w_ready, m0_b_valid, m0_ar_ready, m0_r_valid,
            m1_aw_ready, m1_w_ready, m1_b_valid, m1_ar_ready, m1_r_valid}, 0);
        chk("rst_data", {m0_r_data ^ m1_r_data, s_ar_addr ^ s_aw_addr}, 0);
        rstn = 1;
        repeat (2) @(negedge clk);
        trace.delete();

        // first conflict after reset: master1 wins
        push(1, 0, rdata(64'h100), 0);
        push(0, 0, rdata(64'h200), 0);
        @(posedge clk); #1;
        fork
            do_read(1, 64'h100);
            do_read(0, 64'h200);
        join
        drain();
        check_trace(4, 3'd3, 3'd0, 3'd1, 3'd0);

        // single read with latency and isolation checks
        push(0, 0, rdata(64'h1000), 0);
        c = m1r_cnt;
        @(posedge clk); #1;
        fork
            do_read(0, 64'h1000);
            begin
                @(negedge clk);
                chk("lat_idle_state", grant_state, 0);
                chk("lat_idle_fwd", s_ar_valid, 0);
                chk("idle_no_ready", m0_ar_ready, 0);
                @(negedge clk);
                chk("lat_grant_state", grant_state, 1);
                chk("lat_grant_fwd", s_ar_valid, 1);
                chk("lat_grant_addr", s_ar_addr, 64'h1000);
            end
        join
        drain();
        chk("m1_quiet", m1r_cnt - c, 0);
        check_trace(2, 3'd1, 3'd0, 3'd0, 3'd0);

        // write before read on master1
        push(1, 1, '0, 0);
        push(1, 0, rdata(64'h3000), 0);
        b0 = b_cnt1;
        @(posedge clk); #1;
        fork
            do_write(1, 64'h4000, 128'hdead_beef_0123_4567_89ab_cdef_5555_aaaa);
            do_read(1, 64'h3000);
            begin
                seen = 0;
                for (int i = 0; i < 50 && !seen; i++) begin
                    @(negedge clk);
                    seen = s_ar_valid;
                end
                chk("ar_after_b", b_cnt1 - b0, 1);
            end
        join
        drain();
        chk("wr_addr", sw_addr, 64'h4000);
        chk("wr_data", sw_data, 128'hdead_beef_0123_4567_89ab_cdef_5555_aaaa);
        chk("wr_strb", sw_strb, 16'hffff);
        check_trace(4, 3'd4, 3'd0, 3'd3, 3'd0);

        // second conflict: master1 was granted last, so master0 wins
        push(0, 0, rdata(64'h500), 0);
        push(1, 0, rdata(64'h600), 0);
        @(posedge clk); #1;
        fork
            do_read(0, 64'h500);
            do_read(1, 64'h600);
        join
        drain();
        check_trace(4, 3'd1, 3'd0, 3'd3, 3'd0);

        // split AW/W with SLVERR
        w_gate = 0; b_resp_cfg = 2;
        push(1, 1, '0, 2);
        @(posedge clk); #1;
        fork
            do_write(1, 64'h7000, 128'h77);
            begin
                seen = 0;
                for (int i = 0; i < 20 && !seen; i++) begin
                    @(negedge clk);
                    seen = grant_state == 4;
                end
                chk("split_aw_ready", m1_aw_ready, 1);
                repeat (2) begin
                    @(negedge clk);
                    chk("split_held", grant_state, 4);
                end
                @(posedge clk); #1; w_gate = 1;
                @(negedge clk);
                chk("split_w_cycle4", {grant_state, m1_w_ready}, {3'd4, 1'b1});
            end
        join
        drain();
        b_resp_cfg = 0;
        chk("split_data", sw_data, 128'h77);
        check_trace(2, 3'd4, 3'd0, 3'd0, 3'd0);

        // reset in the middle of a read with response pending
        m0_r_ready = 0;
        @(posedge clk); #1;
        do_read(0, 64'h2000);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = s_r_valid;
        end
        chk("mid_pending", {grant_state, m0_r_valid}, {3'd1, 1'b1});
        #1 rstn = 0;
        #1;
        chk("mid_rst_state", grant_state, 0);
        chk("mid_rst_handshakes", {s_aw_valid, s_w_valid, s_b_ready, s_ar_valid, s_r_ready,
            m0_aw_ready, m0_w_ready, m0_b_valid, m0_ar_ready, m0_r_valid,
            m1_aw_ready, m1_w_ready, m1_b_valid, m1_ar_ready, m1_r_valid}, 0);
        chk("mid_rst_data", m0_r_data, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1; m0_r_ready = 1;
        repeat (2) @(negedge clk);
        trace.delete();
        push(1, 0, rdata(64'h8000), 0);
        @(posedge clk); #1;
        do_read(1, 64'h8000);
        drain();
        check_trace(2, 3'd3, 3'd0, 3'd0, 3'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/axi_lite_mem_arbiter.md
# axi_lite_mem_arbiter

Two-master, one-slave AXI-lite arbiter that shares a single memory path between the instruction-fetch port and the data-memory port of the core. It sits between the core's fetch and data AXI-lite masters and the downstream memory hub or slave. It grants exactly one transaction at a time, uses round-robin fairness on conflicts, and holds the grant until that transaction's response handshake completes.

## Interface
Parameters:
- AXI_ADDR_WIDTH, 64, address width of all channels
- AXI_DATA_WIDTH, 128, data width of all channels; strobe width is AXI_DATA_WIDTH/8

Ports:
- clk  input  1  system clock
- rstn  input  1  reset, asynchronous, active-low
- master0  AXI_ift.Slave  bundle  instruction-fetch master (read-only in practice; write channels still arbitrated)
- master1  AXI_ift.Slave  bundle  data-memory master
- slave  AXI_ift.Master  bundle  shared downstream port
- grant_state  output  3  current FSM state, for debug/cosim

## Operation
- FSM states and encodings:
  - IDLE=0
  - R0=1 (read, master0)
  - W0=2 (write, master0)
  - R1=3 (read, master1)
  - W1=4 (write, master1)
- Request detection in IDLE:
  - req_w(m) = m.aw_valid
  - req_r(m) = m.ar_valid
  - req(m) = req_w(m) | req_r(m)
- Master selection in IDLE:
  - Only one master requesting: select it.
  - Both requesting: select the master not equal to last_grant.
  - last_grant resets to 0, so master1 wins the first conflict.
- Operation selection within the chosen master: write before read if both aw_valid and ar_valid are set.
- IDLE -> Rm or Wm on the next edge. last_grant <= m at the same edge.
- While in Wm:
  - Forward m.aw_*, m.w_*, m.b_ready to slave. Return slave.aw_ready, w_ready, b_valid, b_resp to m.
  - AW and W complete independently.
  - Exit to IDLE on the edge where slave.b_valid & m.b_ready.
- While in Rm:
  - Forward m.ar_*, m.r_ready to slave. Return slave.ar_ready, r_valid, r_data, r_resp to m.
  - Exit to IDLE on the edge where slave.r_valid & m.r_ready.
- Non-granted master, and any channel not belonging to the active operation:
  - All ready and valid outputs driven 0.
  - Data and response outputs driven 0.
- Error responses (resp != 0) pass through unchanged and end the transaction normally.
- Exactly one outstanding transaction. No ID reordering. No buffering of payloads; all channel muxing is combinational from the registered state.

## Timing
- Reset (rstn=0, asynchronous):
  - state=IDLE, last_grant=0, grant_state=0.
  - All valid/ready outputs on every port are 0; data outputs are 0.
- Reset asserted mid-transaction: FSM returns to IDLE immediately and drops all forwarded valids. The transaction is abandoned, with no completion signalled.
- Arbitration latency: request visible in IDLE cycle N, so the slave sees the forwarded valid in cycle N+1.
- Post-response bubble: the response handshake in cycle K gives IDLE in K+1, and the next grant becomes visible in K+2.
- Back-to-back requests from one master with the other idle: one transaction per 2 + slave latency cycles.
- Rule: a slave ready is never reflected to a master in IDLE, so no handshake can occur without a grant.
- Requests arriving while busy are held by the master (AXI valid-stability rule) and are evaluated on the next IDLE.
- Simultaneous request and response completion: the response completes the current grant. The new request is arbitrated in the following IDLE cycle.

## Test plan
- Single read: master0 ar_addr=0x1000, slave answers r_data=0x1122…, r_resp=0 two cycles after ar handshake.
  - Required: grant_state 0->1->0; master0 receives the data.
  - Required: master1 sees r_valid=0 throughout.
- Conflict fairness: both masters assert ar_valid in the same IDLE cycle after reset.
  - Required: master1 is served first (state 3), then master0 (state 1).
  - Repeat the conflict: master0 is served first.
- Data write priority: master1 asserts aw_valid, w_valid and ar_valid together.
  - Required: state 4 is entered first; the b handshake occurs; then IDLE; then state 3.
  - Required: the read address reaches the slave only after b_resp.
- Split AW/W: the slave accepts AW at cycle 1 and W at cycle 4, then b_resp=2 (SLVERR).
  - Required: the grant is held through cycle 4 and b_resp=2 is delivered to master1.
  - Required: exit to IDLE occurs only on the b handshake.
- Reset mid-read: rstn pulled low while in state 1 with slave.r_valid pending.
  - Required: grant_state=0 and all valid/ready outputs are 0 in the same cycle.
  - Required: after release, a new master1 read completes normally.
